// File: rtl/audio_mix_sched.sv
// Purpose : schedules codec init, then fetches/mixes one music (+ optional effect) sample per data_over edge.
// Latency : data_over edge to LDATA/RDATA is 3 cycles plus source ack waits (4 with an effect fetch).
// Backpres: sources are request/ack level handshakes with a TIMEOUT fallback; one event may queue while busy, further ones count as underruns.
//
// Ports:
//   CLK, RESET                 clock, synchronous active-high reset
//   INIT / INIT_FINISH         codec init request / completion level
//   data_over                  codec consumed the current sample (rising edge = event)
//   LDATA, RDATA               registered signed mix result
//   mus_req/mus_ack/mus_data   music sample handshake
//   sfx_active/sfx_req/sfx_ack/sfx_data  effect sample handshake
//   running                    init complete, serving samples
//   underrun_cnt               saturating count of fetch timeouts and lost events
//
// Build option: define SFX_MIX_EN to fetch and mix effect samples; without it only music is passed through.

module audio_mix_sched #(
  parameter int TIMEOUT   = 64,
  parameter int SFX_SHIFT = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic        INIT,
  input  logic        INIT_FINISH,
  input  logic        data_over,
  output logic [15:0] LDATA,
  output logic [15:0] RDATA,
  output logic        mus_req,
  input  logic        mus_ack,
  input  logic [15:0] mus_data,
  input  logic        sfx_active,
  output logic        sfx_req,
  input  logic        sfx_ack,
  input  logic [15:0] sfx_data,
  output logic        running,
  output logic [7:0]  underrun_cnt
);

  typedef enum logic [2:0] {
    INIT_WAIT = 3'd0,
    IDLE      = 3'd1,
    FETCH_MUS = 3'd2,
    FETCH_SFX = 3'd3,
    MIX       = 3'd4
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t             state, state_n;
  logic               data_over_q;
  logic               pending, pending_n;
  logic [7:0]         wait_cnt, wait_cnt_n;
  logic signed [15:0] mus_q, mus_n;
  logic signed [15:0] mix_out;
  logic               evt;
  logic               timeout_hit;
  logic               tmo;
  logic               lost_evt;

  assign evt         = data_over & ~data_over_q;
  assign timeout_hit = (wait_cnt == TO_LAST);

`ifdef SFX_MIX_EN
  logic signed [15:0] sfx_q, sfx_n;
  logic signed [15:0] sfx_sh;
  logic signed [16:0] mix_sum;

  assign sfx_sh  = sfx_q >>> SFX_SHIFT;
  assign mix_sum = {mus_q[15], mus_q} + {sfx_sh[15], sfx_sh};
  // Overflow of the 17-bit sum shows up as the top two bits disagreeing.
  assign mix_out = (mix_sum[16] != mix_sum[15]) ? (mix_sum[16] ? 16'sh8000 : 16'sh7FFF)
                                                : mix_sum[15:0];
`else
  logic unused_sfx;
  localparam int unused_sfx_shift = SFX_SHIFT;

  assign unused_sfx = ^{sfx_active, sfx_ack, sfx_data};
  assign mix_out    = mus_q;
`endif

  always_comb begin
    state_n    = state;
    pending_n  = pending;
    wait_cnt_n = 8'd0;
    mus_n      = mus_q;
`ifdef SFX_MIX_EN
    sfx_n      = sfx_q;
`endif
    tmo        = 1'b0;
    lost_evt   = 1'b0;
    INIT       = 1'b0;
    running    = 1'b1;
    mus_req    = 1'b0;
    sfx_req    = 1'b0;

    // Events arriving while a sample is in flight queue one deep; the rest are lost.
    if ((state == FETCH_MUS || state == FETCH_SFX || state == MIX) && evt) begin
      if (pending) lost_evt  = 1'b1;
      else         pending_n = 1'b1;
    end

    case (state)
      INIT_WAIT: begin
        INIT    = 1'b1;
        running = 1'b0;
        if (INIT_FINISH) state_n = IDLE;
      end
      IDLE: begin
        if (evt || pending) begin
          state_n   = FETCH_MUS;
          // A queued event is served first; a fresh edge in the same cycle takes its slot.
          pending_n = evt & pending;
        end
      end
      FETCH_MUS: begin
        mus_req = 1'b1;
        if (mus_ack || timeout_hit) begin
          mus_n = mus_ack ? mus_data : 16'sd0;
          tmo   = ~mus_ack;
`ifdef SFX_MIX_EN
          if (sfx_active) begin
            state_n = FETCH_SFX;
          end else begin
            state_n = MIX;
            sfx_n   = 16'sd0;
          end
`else
          state_n = MIX;
`endif
        end
      end
      FETCH_SFX: begin
`ifdef SFX_MIX_EN
        sfx_req = 1'b1;
        if (sfx_ack || timeout_hit) begin
          sfx_n   = sfx_ack ? sfx_data : 16'sd0;
          tmo     = ~sfx_ack;
          state_n = MIX;
        end
`else
        state_n = MIX;
`endif
      end
      MIX: begin
        state_n = IDLE;
      end
      default: begin
        state_n = INIT_WAIT;
      end
    endcase

    // The wait counter restarts from zero on every entry to a fetch state.
    if ((state == FETCH_MUS || state == FETCH_SFX) && state_n == state)
      wait_cnt_n = wait_cnt + 8'd1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= INIT_WAIT;
      data_over_q  <= 1'b0;
      pending      <= 1'b0;
      wait_cnt     <= 8'd0;
      mus_q        <= 16'sd0;
`ifdef SFX_MIX_EN
      sfx_q        <= 16'sd0;
`endif
      LDATA        <= 16'd0;
      RDATA        <= 16'd0;
      underrun_cnt <= 8'd0;
    end else begin
      state       <= state_n;
      data_over_q <= data_over;
      pending     <= pending_n;
      wait_cnt    <= wait_cnt_n;
      mus_q       <= mus_n;
`ifdef SFX_MIX_EN
      sfx_q       <= sfx_n;
`endif
      if (state == MIX) begin
        LDATA <= mix_out;
        RDATA <= mix_out;
      end
      // Simultaneous timeout and lost event count once.
      if ((tmo || lost_evt) && underrun_cnt != 8'hFF)
        underrun_cnt <= underrun_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_audio_mix_sched.sv
// Purpose : self-checking bench for audio_mix_sched against a job-schedule reference model.
// Latency : model predicts every output per cycle from planned ack delays and sample values.
// Backpres: acks are generated from the model's own schedule, never from DUT requests.

module tb_audio_mix_sched;

  localparam int TO = 64;
  localparam int SH = 1;
`ifdef SFX_MIX_EN
  localparam bit SFX_EN = 1'b1;
`else
  localparam bit SFX_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET;
  logic        INIT;
  logic        INIT_FINISH;
  logic        data_over;
  logic [15:0] LDATA, RDATA;
  logic        mus_req, mus_ack;
  logic [15:0] mus_data;
  logic        sfx_active, sfx_req, sfx_ack;
  logic [15:0] sfx_data;
  logic        running;
  logic [7:0]  underrun_cnt;

  audio_mix_sched #(.TIMEOUT(TO), .SFX_SHIFT(SH)) dut (
    .CLK(CLK), .RESET(RESET), .INIT(INIT), .INIT_FINISH(INIT_FINISH),
    .data_over(data_over), .LDATA(LDATA), .RDATA(RDATA),
    .mus_req(mus_req), .mus_ack(mus_ack), .mus_data(mus_data),
    .sfx_active(sfx_active), .sfx_req(sfx_req), .sfx_ack(sfx_ack), .sfx_data(sfx_data),
    .running(running), .underrun_cnt(underrun_cnt)
  );

  always #10 CLK = ~CLK;

  // check bookkeeping
  int          nchk = 0, nerr = 0;
  int          cyc = 0;
  bit          chk_en = 1'b0;
  logic        exp_init, exp_run, exp_mreq, exp_sreq;
  logic [15:0] exp_ld;
  logic [7:0]  exp_under;
  bit          lit_en = 1'b0;
  int          lit_sel;
  logic [31:0] lit_exp;
  string       lit_name;
  int          mreq_cnt = 0, mjob_cnt = 0;
  bit          mreq_prev = 1'b0;

  // reference model: one planned job at a time
  bit          m_run, job, pend, prev_do;
  bit          mus_to, sfx_to, sfx_on;
  int          t0, me, s0, se, mixc, dm, ds;
  logic [15:0] pm, ps, job_val, m_out;
  logic [7:0]  m_under;

  // stimulus knobs
  bit          rst_i, if_i, do_i, p_sa;
  bit          dir_en, dir_sa;
  int          dir_dm, dir_ds;
  logic [15:0] dir_md, dir_sd;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge CLK) begin : compare_p
    logic [31:0] act;
    if (chk_en) begin
      cmp("INIT",         32'(INIT),         32'(exp_init));
      cmp("running",      32'(running),      32'(exp_run));
      cmp("mus_req",      32'(mus_req),      32'(exp_mreq));
      cmp("sfx_req",      32'(sfx_req),      32'(exp_sreq));
      cmp("LDATA",        32'(LDATA),        32'(exp_ld));
      cmp("RDATA",        32'(RDATA),        32'(exp_ld));
      cmp("underrun_cnt", 32'(underrun_cnt), 32'(exp_under));
      if (lit_en) begin
        case (lit_sel)
          0:       act = 32'(LDATA);
          1:       act = 32'(RDATA);
          2:       act = 32'(underrun_cnt);
          3:       act = 32'(running);
          4:       act = 32'(INIT);
          5:       act = 32'(mreq_cnt);
          6:       act = 32'(mjob_cnt);
          7:       act = 32'(mus_req);
          default: act = 'x;
        endcase
        cmp(lit_name, act, lit_exp);
      end
    end
  end

  function automatic logic [15:0] mix_model(input logic [15:0] m, input logic [15:0] s, input bit use_s);
    int a, b, r;
    a = int'($signed(m));
    b = int'($signed(s));
    b = b >>> SH;
    if (!SFX_EN || !use_s) b = 0;
    r = a + b;
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return 16'(r);
  endfunction

  function automatic int rnd_delay();
    int r;
    r = $urandom_range(0, 99);
    if (r < 60) return $urandom_range(0, 3);
    if (r < 90) return $urandom_range(4, TO - 1);
    return $urandom_range(TO, TO + 5);
  endfunction

  task automatic plan(input int t);
    t0 = t;
    if (dir_en) begin
      dm = dir_dm; ds = dir_ds; pm = dir_md; ps = dir_sd; p_sa = dir_sa;
    end else begin
      dm = rnd_delay(); ds = rnd_delay();
      pm = 16'($urandom); ps = 16'($urandom);
      p_sa = 1'($urandom_range(0, 1));
    end
    mus_to  = (dm >= TO);
    me      = t0 + (mus_to ? TO - 1 : dm);
    sfx_on  = SFX_EN && p_sa;
    sfx_to  = (ds >= TO);
    s0      = me + 1;
    se      = s0 + (sfx_to ? TO - 1 : ds);
    mixc    = sfx_on ? se + 1 : me + 1;
    job_val = mix_model(mus_to ? 16'h0 : pm, (sfx_on && !sfx_to) ? ps : 16'h0, sfx_on);
    job     = 1'b1;
  endtask

  task automatic lit(input string nm, input int sel, input logic [31:0] e);
    lit_name = nm; lit_sel = sel; lit_exp = e; lit_en = 1'b1;
  endtask

  // One clock cycle: drive inputs, publish expectations, advance the model.
  task automatic tick();
    bit ev, inc, in_m, in_s;
    in_m = job && cyc >= t0 && cyc <= me;
    in_s = job && sfx_on && cyc >= s0 && cyc <= se;
    RESET       = rst_i;
    INIT_FINISH = if_i;
    data_over   = do_i;
    sfx_active  = p_sa;
    mus_data    = 16'($urandom);
    sfx_data    = 16'($urandom);
    mus_ack     = 1'b0;
    sfx_ack     = 1'b0;
    if (in_m) begin
      if (!mus_to && cyc == t0 + dm) begin mus_ack = 1'b1; mus_data = pm; end
    end else begin
      mus_ack = ($urandom_range(0, 5) == 0);
    end
    if (in_s) begin
      if (!sfx_to && cyc == s0 + ds) begin sfx_ack = 1'b1; sfx_data = ps; end
    end else begin
      sfx_ack = ($urandom_range(0, 5) == 0);
    end

    exp_init  = !m_run;
    exp_run   = m_run;
    exp_mreq  = in_m;
    exp_sreq  = in_s;
    exp_ld    = m_out;
    exp_under = m_under;

    ev = do_i && !prev_do;
    if (rst_i) begin
      m_run = 0; job = 0; pend = 0; m_under = 8'd0; m_out = 16'd0; prev_do = 0;
    end else begin
      inc = (in_m && mus_to && cyc == me) || (in_s && sfx_to && cyc == se);
      if (!m_run) begin
        if (if_i) m_run = 1'b1;
      end else if (!job) begin
        if (ev || pend) begin
          pend = ev && pend;
          plan(cyc + 1);
        end
      end else begin
        if (ev) begin
          if (pend) inc = 1'b1;
          else      pend = 1'b1;
        end
        if (cyc == mixc) begin
          m_out = job_val;
          job   = 1'b0;
        end
      end
      if (inc && m_under != 8'd255) m_under = m_under + 8'd1;
      prev_do = do_i;
    end

    @(negedge CLK);
    if (mus_req === 1'b1) mreq_cnt++;
    if (mus_req === 1'b1 && !mreq_prev) mjob_cnt++;
    mreq_prev = (mus_req === 1'b1);
    #1 lit_en = 1'b0;
    @(posedge CLK);
    #1 cyc++;
  endtask

  task automatic drain();
    int n = 0;
    while ((job || pend) && n < 400) begin tick(); n++; end
    tick(); tick();
  endtask

  // data_over high for two cycles then low; the event lands in the first cycle.
  task automatic edge_evt();
    do_i = 1'b1; tick(); tick(); do_i = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; INIT_FINISH = 1'b0; data_over = 1'b0; mus_ack = 1'b0; sfx_ack = 1'b0;
    mus_data = 16'd0; sfx_data = 16'd0; sfx_active = 1'b0;
    rst_i = 1; if_i = 0; do_i = 0; p_sa = 0;
    dir_en = 1; dir_sa = 1; dir_dm = 0; dir_ds = 0; dir_md = 16'h0; dir_sd = 16'h0;
    m_run = 0; job = 0; pend = 0; prev_do = 0; m_under = 8'd0; m_out = 16'd0;
    t0 = 0; me = 0; s0 = 0; se = 0; mixc = 0; dm = 0; ds = 0;
    mus_to = 0; sfx_to = 0; sfx_on = 0; pm = 16'h0; ps = 16'h0; job_val = 16'h0;
    @(posedge CLK); #1;

    // init sequence
    tick(); chk_en = 1'b1; tick();
    rst_i = 0;
    lit("rst_under", 2, 32'd0); tick();
    for (int i = 0; i < 8; i++) tick();
    lit("init_hold", 4, 32'd1); tick();
    if_i = 1; tick();
    lit("run_after_finish", 3, 32'd1); tick();
    lit("init_drop", 4, 32'd0); tick();
    if_i = 0; tick(); tick();

    // basic mix, zero-wait acks
    dir_dm = 0; dir_ds = 0; dir_md = 16'h1000; dir_sd = 16'h2000; dir_sa = 1;
    edge_evt(); tick();
    lit("mix_latency", 0, SFX_EN ? 32'h0 : 32'h1000); tick();
    lit("mix_basic", 0, SFX_EN ? 32'h2000 : 32'h1000); tick();
    drain();

    // saturation both directions
    dir_md = 16'h7000; dir_sd = 16'h7FFF;
    edge_evt(); tick(); tick();
    lit("sat_pos", 1, SFX_EN ? 32'h7FFF : 32'h7000); tick();
    drain();
    dir_md = 16'h9000; dir_sd = 16'h8000;
    edge_evt(); tick(); tick();
    lit("sat_neg", 0, SFX_EN ? 32'h8000 : 32'h9000); tick();
    drain();

    // music timeout
    dir_dm = TO + 10; dir_ds = 0; dir_md = 16'h1234; dir_sd = 16'h2000; dir_sa = 1;
    mreq_cnt = 0;
    edge_evt(); drain();
    lit("tmo_req_len", 5, 32'(TO)); tick();
    lit("tmo_out", 0, SFX_EN ? 32'h1000 : 32'h0); tick();
    lit("tmo_under", 2, 32'd1); tick();

    // overrun during a slow fetch
    dir_dm = 40; dir_ds = 0; dir_sa = 0; dir_md = 16'h0ABC;
    mjob_cnt = 0;
    do_i = 1; tick(); do_i = 0;
    for (int i = 0; i < 4; i++) tick();
    do_i = 1; tick(); do_i = 0;
    for (int i = 0; i < 4; i++) tick();
    do_i = 1; tick(); do_i = 0;
    drain();
    lit("ovr_jobs", 6, 32'd2); tick();
    lit("ovr_under", 2, 32'd2); tick();

    // randomized traffic
    dir_en = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0)  do_i = ~do_i;
      if ($urandom_range(0, 49) == 0) if_i = ~if_i;
      tick();
    end
    do_i = 0; drain();

    // flood of events to saturate underrun_cnt
    dir_en = 1; dir_dm = 30; dir_ds = 30; dir_sa = 1; dir_md = 16'h0100; dir_sd = 16'h0200;
    for (int i = 0; i < 1200; i++) begin do_i = ~do_i; tick(); end
    do_i = 0; drain();
    lit("under_sat", 2, 32'd255); tick();

    // reset in the middle of a fetch
    dir_dm = 50; dir_sa = 0;
    do_i = 1; tick(); do_i = 0;
    for (int i = 0; i < 5; i++) tick();
    lit("pre_rst_mreq", 7, 32'd1); tick();
    rst_i = 1; if_i = 0; tick();
    rst_i = 0;
    lit("rst_mid_under", 2, 32'd0); tick();
    lit("rst_mid_mreq", 7, 32'd0); tick();
    lit("rst_mid_ldata", 0, 32'd0); tick();
    lit("rst_mid_init", 4, 32'd1); tick();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
